// File: rtl/hazard_manager.sv
// hazard_manager: stall, IF/ID flush and operand-forwarding control for the 5-stage pipeline.
// Keeps private EXECUTE/MEMORY/WRITEBACK register-number copies that advance with control_path.
module hazard_manager #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] rs_D,
   input  logic [REG_W-1:0] rt_D,
   input  logic             useRs_D,
   input  logic             useRt_D,
   input  logic [REG_W-1:0] dst_D,
   input  logic             branch_D,
   input  logic             redirect_D,
   input  logic             wriSigEXEC,
   input  logic             wriSigMEMO,
   input  logic             wriSigWRIT,
   input  logic             wriRegFromMemEXEC,
   input  logic             wriRegFromMemMEMO,
   output logic             stall,
   output logic             flushD,
   output logic [1:0]       fwdA_E,
   output logic [1:0]       fwdB_E,
   output logic             fwdA_D,
   output logic             fwdB_D,
   output logic [CNT_W-1:0] stallCount
);
   logic [REG_W-1:0] dst_e_q, rs_e_q, rt_e_q, dst_m_q, dst_w_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit_e, hit_m, stall_d, alu_m;

   // Register 0 is hardwired, so it never matches a producer.
   assign hit_e = (useRs_D && rs_D == dst_e_q && |rs_D) || (useRt_D && rt_D == dst_e_q && |rt_D);
   assign hit_m = (useRs_D && rs_D == dst_m_q && |rs_D) || (useRt_D && rt_D == dst_m_q && |rt_D);
   assign stall_d = (wriRegFromMemEXEC && hit_e) || (branch_D && wriSigEXEC && hit_e) ||
                    (branch_D && wriRegFromMemMEMO && hit_m);
   assign alu_m = wriSigMEMO && !wriRegFromMemMEMO;
   assign cnt_d = (stall_d && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

   always_comb begin
      stall      = rst && stall_d;
      flushD     = rst && redirect_D && !stall_d;
      fwdA_E     = !rst ? 2'b00 :
                   (alu_m && dst_m_q == rs_e_q && |rs_e_q) ? 2'b10 :
                   (wriSigWRIT && dst_w_q == rs_e_q && |rs_e_q) ? 2'b01 : 2'b00;
      fwdB_E     = !rst ? 2'b00 :
                   (alu_m && dst_m_q == rt_e_q && |rt_e_q) ? 2'b10 :
                   (wriSigWRIT && dst_w_q == rt_e_q && |rt_e_q) ? 2'b01 : 2'b00;
      fwdA_D     = rst && alu_m && dst_m_q == rs_D && |rs_D;
      fwdB_D     = rst && alu_m && dst_m_q == rt_D && |rt_D;
      stallCount = rst ? cnt_q : '0;
   end

   // A stall turns the EXECUTE copy into a bubble; MEMORY and WRITEBACK always advance.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dst_e_q <= '0;
         rs_e_q  <= '0;
         rt_e_q  <= '0;
         dst_m_q <= '0;
         dst_w_q <= '0;
         cnt_q   <= '0;
      end else begin
         dst_e_q <= stall_d ? '0 : dst_D;
         rs_e_q  <= stall_d ? '0 : rs_D;
         rt_e_q  <= stall_d ? '0 : rt_D;
         dst_m_q <= dst_e_q;
         dst_w_q <= dst_m_q;
         cnt_q   <= cnt_d;
      end
   end
endmodule
